// File: rtl/baud_pkg.sv
// baud_pkg: shared divisor defaults and the clock/baud to fixed-point divisor helper
package baud_pkg;
  // Rounded divisor in units of 1/2^frac_w clock cycles per oversample tick.
  function automatic int unsigned baud_div_q(longint unsigned clk_hz, longint unsigned baud,
                                             int unsigned os, int unsigned frac_w);
    longint unsigned den = baud * os;
    return 32'(((clk_hz << frac_w) + den / 2) / den);
  endfunction
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DIV_FRAC_W_DEF = 4;
  localparam int unsigned MIN_DIV_INT = 2;
  localparam int unsigned DIV_Q_DEF = baud_div_q(64'd50_000_000, 64'd115_200, OVERSAMPLE_DEF, DIV_FRAC_W_DEF);
  localparam int unsigned RST_DIV_INT_DEF = DIV_Q_DEF >> DIV_FRAC_W_DEF;
  localparam int unsigned RST_DIV_FRAC_DEF = DIV_Q_DEF % (32'd1 << DIV_FRAC_W_DEF);
endpackage

// File: rtl/baud_frac_gen_if.sv
// baud_frac_gen_if: divisor control, resync and tick outputs of the baud generator
interface baud_frac_gen_if #(
  parameter int DIV_INT_W = 16,
  parameter int DIV_FRAC_W = 4
);
  logic en, div_load, rx_resync, rxclk_en, rx_sample, txclk_en, div_err;
  logic [DIV_INT_W-1:0] div_int;
  logic [DIV_FRAC_W-1:0] div_frac;
  modport master(output en, div_int, div_frac, div_load, rx_resync,
                 input rxclk_en, rx_sample, txclk_en, div_err);
  modport slave(input en, div_int, div_frac, div_load, rx_resync,
                output rxclk_en, rx_sample, txclk_en, div_err);
endinterface

// File: rtl/baud_frac_div.sv
// baud_frac_div: fractional-N oversample tick engine with divisor loads deferred to tick boundaries
module baud_frac_div
  import baud_pkg::*;
#(
  parameter int DIV_INT_W = 16,
  parameter int DIV_FRAC_W = 4,
  parameter int RST_DIV_INT = int'(RST_DIV_INT_DEF),
  parameter int RST_DIV_FRAC = int'(RST_DIV_FRAC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [DIV_INT_W-1:0]  div_int_i,
  input  logic [DIV_FRAC_W-1:0] div_frac_i,
  input  logic                  div_load_i,
  output logic                  tick_o,
  output logic                  rxclk_en_o,
  output logic                  div_err_o
);
  localparam logic [DIV_INT_W-1:0] MIN_INT = DIV_INT_W'(MIN_DIV_INT);
  logic [DIV_INT_W-1:0] act_int_q, act_int_d, cnt_q, cnt_d, pend_int_q, ld_int;
  logic [DIV_FRAC_W-1:0] act_frac_q, act_frac_d, facc_q, facc_d, facc_base, pend_frac_q;
  logic [DIV_FRAC_W:0] sum;
  logic pend_q, pend_d, err_q, err_d, tick_q, apply;
  always_comb begin
    ld_int = div_int_i < MIN_INT ? MIN_INT : div_int_i;
    tick_o = en_i && cnt_q == '0;
    apply = tick_o && (div_load_i || pend_q);
    act_int_d = !apply ? act_int_q : div_load_i ? ld_int : pend_int_q;
    act_frac_d = !apply ? act_frac_q : div_load_i ? div_frac_i : pend_frac_q;
    // a freshly applied divisor starts its fractional phase from zero
    facc_base = apply ? '0 : facc_q;
    sum = {1'b0, facc_base} + {1'b0, act_frac_d};
    facc_d = tick_o ? sum[DIV_FRAC_W-1:0] : facc_q;
    cnt_d = tick_o ? act_int_d - DIV_INT_W'(1) + DIV_INT_W'(sum[DIV_FRAC_W])
          : en_i ? cnt_q - DIV_INT_W'(1) : cnt_q;
    pend_d = !tick_o && (div_load_i || pend_q);
    err_d = div_load_i ? div_int_i < MIN_INT : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      act_int_q <= DIV_INT_W'(RST_DIV_INT);
      act_frac_q <= DIV_FRAC_W'(RST_DIV_FRAC);
      cnt_q <= '0;
      facc_q <= '0;
      pend_q <= 1'b0;
      pend_int_q <= '0;
      pend_frac_q <= '0;
      err_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      act_int_q <= act_int_d;
      act_frac_q <= act_frac_d;
      cnt_q <= cnt_d;
      facc_q <= facc_d;
      pend_q <= pend_d;
      pend_int_q <= div_load_i ? ld_int : pend_int_q;
      pend_frac_q <= div_load_i ? div_frac_i : pend_frac_q;
      err_q <= err_d;
      tick_q <= tick_o;
    end
  end
  assign rxclk_en_o = tick_q;
  assign div_err_o = err_q;
endmodule

// File: rtl/baud_frac_gen.sv
// baud_frac_gen: fractional baud tick generator with tx bit tick and resyncable rx mid-bit strobe
module baud_frac_gen
  import baud_pkg::*;
#(
  parameter int DIV_INT_W = 16,
  parameter int DIV_FRAC_W = int'(DIV_FRAC_W_DEF),
  parameter int OVERSAMPLE = int'(OVERSAMPLE_DEF),
  parameter int RST_DIV_INT = int'(RST_DIV_INT_DEF),
  parameter int RST_DIV_FRAC = int'(RST_DIV_FRAC_DEF)
) (
  input logic clk,
  input logic rst,
  baud_frac_gen_if.slave bus
);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_MID = OW'(OVERSAMPLE / 2);
  logic tick, rx_arm_q, txclk_en_q, rx_sample_q;
  logic [OW-1:0] tx_os_q, tx_os_d, rx_os_q, rx_os_d;
  baud_frac_div #(
    .DIV_INT_W(DIV_INT_W),
    .DIV_FRAC_W(DIV_FRAC_W),
    .RST_DIV_INT(RST_DIV_INT),
    .RST_DIV_FRAC(RST_DIV_FRAC)
  ) u_div (
    .clk(clk),
    .rst(rst),
    .en_i(bus.en),
    .div_int_i(bus.div_int),
    .div_frac_i(bus.div_frac),
    .div_load_i(bus.div_load),
    .tick_o(tick),
    .rxclk_en_o(bus.rxclk_en),
    .div_err_o(bus.div_err)
  );
  always_comb begin
    tx_os_d = tick ? tx_os_q + OW'(1) : tx_os_q;
    // resync beats a coincident tick, so that tick is not counted in the rx phase
    rx_os_d = bus.rx_resync ? '0 : tick ? rx_os_q + OW'(1) : rx_os_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_os_q <= '0;
      rx_os_q <= '0;
      rx_arm_q <= 1'b0;
      txclk_en_q <= 1'b0;
      rx_sample_q <= 1'b0;
    end else begin
      tx_os_q <= tx_os_d;
      rx_os_q <= rx_os_d;
      rx_arm_q <= rx_arm_q || bus.rx_resync;
      txclk_en_q <= tick && tx_os_q == OS_LAST;
      rx_sample_q <= tick && rx_arm_q && !bus.rx_resync && rx_os_d == OS_MID;
    end
  end
  assign bus.txclk_en = txclk_en_q;
  assign bus.rx_sample = rx_sample_q;
endmodule
